// File: rtl/mul_wb_seq.sv
// mul_wb_seq: sequences one 8x8 multiply through an external combinational
// multiplier and writes the 16-bit product back as two register-file writes:
// the low byte to rd, then the high byte to rd+1 (wrapping).
module mul_wb_seq #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        op_a,
    input  logic [7:0]        op_b,
    input  logic [ADDR_W-1:0] rd,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       prod_in,
    input  logic              wb_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [7:0]        rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              ovf
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WR_LO = 2'd2,
        ST_WR_HI = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mul_a;
    logic [DATA_W-1:0]   r_mul_b;
    logic [ADDR_W-1:0]   r_rd_q;
    logic [PROD_W-1:0]   r_prod_q;
    logic                r_zero;
    logic                r_ovf;
    logic                r_busy;

    logic                w_rf_we;
    logic [ADDR_W-1:0]   w_rf_waddr;
    logic [DATA_W-1:0]   w_rf_wdata;
    logic                w_done;
    logic [ADDR_W-1:0]   w_rd_hi;

    // High byte goes to the next register; natural wrap at 2^ADDR_W.
    assign w_rd_hi = r_rd_q + ADDR_W'(1);

    // Sequencer: accepts start only in IDLE, captures the product after the
    // one-cycle CALC window, then steps through the two stallable writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_rd_q   <= '0;
            r_prod_q <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mul_a <= op_a;
                        r_mul_b <= op_b;
                        r_rd_q  <= rd;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_prod_q <= prod_in;
                    r_zero   <= (prod_in == PROD_W'(0));
                    r_ovf    <= |prod_in[PROD_W-1:DATA_W];
                    r_state  <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (!wb_stall) begin
                        r_state <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (!wb_stall) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-port decode; address and data are zero whenever no write occurs.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = '0;
        w_rf_wdata = '0;
        w_done     = 1'b0;
        if (!wb_stall) begin
            case (r_state)
                ST_WR_LO: begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = r_rd_q;
                    w_rf_wdata = r_prod_q[DATA_W-1:0];
                end
                ST_WR_HI: begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = w_rd_hi;
                    w_rf_wdata = r_prod_q[PROD_W-1:DATA_W];
                    w_done     = 1'b1;
                end
                default: begin
                    w_rf_we = 1'b0;
                end
            endcase
        end
    end

    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign rf_we    = w_rf_we;
    assign rf_waddr = w_rf_waddr;
    assign rf_wdata = w_rf_wdata;
    assign done     = w_done;
    assign busy     = r_busy;
    assign zero     = r_zero;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_mul_wb_seq.sv
// Bench for mul_wb_seq: transaction-level reference model plus per-cycle
// comparison, directed literal cases and a randomized phase.
module tb_mul_wb_seq;

    localparam int unsigned ADDR_W = 3;
    localparam int          NREG   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        op_a = 8'h00;
    logic [7:0]        op_b = 8'h00;
    logic [ADDR_W-1:0] rd = '0;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       prod_in;
    logic              wb_stall = 1'b0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [7:0]        rf_wdata;
    logic              busy;
    logic              done;
    logic              zero;
    logic              ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mul_wb_seq #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd       (rd),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .prod_in  (prod_in),
        .wb_stall (wb_stall),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .done     (done),
        .zero     (zero),
        .ovf      (ovf)
    );

    // External combinational multiplier
    assign prod_in = {8'h00, mul_a} * {8'h00, mul_b};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: an operation is a phase index (0 idle, 1 multiply,
    // 2 low-byte write pending, 3 high-byte write pending) plus its operands.
    int m_ph   = 0;
    int m_a    = 0;
    int m_b    = 0;
    int m_rd   = 0;
    int m_p    = 0;
    int m_zero = 0;
    int m_ovf  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_a <= 0; m_b <= 0; m_rd <= 0; m_p <= 0; m_zero <= 0; m_ovf <= 0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    m_a  <= int'(op_a);
                    m_b  <= int'(op_b);
                    m_rd <= int'(rd);
                    m_p  <= int'(op_a) * int'(op_b);
                    m_ph <= 1;
                end
                1: begin
                    m_zero <= (m_p == 0) ? 1 : 0;
                    m_ovf  <= (m_p > 255) ? 1 : 0;
                    m_ph   <= 2;
                end
                2: if (!wb_stall) m_ph <= 3;
                default: if (!wb_stall) m_ph <= 0;
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int e_we, e_addr, e_data, e_done;
        e_we   = ((m_ph == 2 || m_ph == 3) && !wb_stall) ? 1 : 0;
        e_done = (m_ph == 3 && !wb_stall) ? 1 : 0;
        e_addr = 0;
        e_data = 0;
        if (e_we == 1) begin
            e_addr = (m_ph == 2) ? m_rd : (m_rd + 1) % NREG;
            e_data = (m_ph == 2) ? (m_p % 256) : (m_p / 256);
        end
        chk("cmp_we",    32'(rf_we),    32'(e_we));
        chk("cmp_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("cmp_wdata", 32'(rf_wdata), 32'(e_data));
        chk("cmp_done",  32'(done),     32'(e_done));
        chk("cmp_busy",  32'(busy),     32'((m_ph != 0) ? 1 : 0));
        chk("cmp_mul_a", 32'(mul_a),    32'(m_a));
        chk("cmp_mul_b", 32'(mul_b),    32'(m_b));
        chk("cmp_zero",  32'(zero),     32'(m_zero));
        chk("cmp_ovf",   32'(ovf),      32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed op with hand-computed expectations; called just after a
    // rising edge with the block idle.
    task automatic op_lit(input logic [7:0] a, input logic [7:0] b, input logic [2:0] r,
                          input logic [2:0] lo_a, input logic [7:0] lo_d,
                          input logic [2:0] hi_a, input logic [7:0] hi_d,
                          input logic zr, input logic ov);
        start = 1'b1; op_a = a; op_b = b; rd = r; wb_stall = 1'b0;
        tick();
        start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); rd = 3'($urandom);
        @(negedge clk);
        chk("lit_calc_busy", 32'(busy), 32'd1);
        chk("lit_calc_we",   32'(rf_we), 32'd0);
        chk("lit_calc_mula", 32'(mul_a), 32'(a));
        tick();
        @(negedge clk);
        chk("lit_lo_we",   32'(rf_we),    32'd1);
        chk("lit_lo_addr", 32'(rf_waddr), 32'(lo_a));
        chk("lit_lo_data", 32'(rf_wdata), 32'(lo_d));
        chk("lit_lo_done", 32'(done),     32'd0);
        chk("lit_zero",    32'(zero),     32'(zr));
        chk("lit_ovf",     32'(ovf),      32'(ov));
        tick();
        @(negedge clk);
        chk("lit_hi_we",   32'(rf_we),    32'd1);
        chk("lit_hi_addr", 32'(rf_waddr), 32'(hi_a));
        chk("lit_hi_data", 32'(rf_wdata), 32'(hi_d));
        chk("lit_hi_done", 32'(done),     32'd1);
        tick();
        @(negedge clk);
        chk("lit_end_busy", 32'(busy),  32'd0);
        chk("lit_end_we",   32'(rf_we), 32'd0);
        tick();
    endtask

    initial begin
        int c0;
        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(rf_we), 32'd0);
        chk("rst_mula", 32'(mul_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic, wrap+overflow, zero product
        op_lit(8'h0C, 8'h0A, 3'd2, 3'd2, 8'h78, 3'd3, 8'h00, 1'b0, 1'b0);
        op_lit(8'hFF, 8'hFF, 3'd7, 3'd7, 8'h01, 3'd0, 8'hFE, 1'b0, 1'b1);
        op_lit(8'h00, 8'h5A, 3'd4, 3'd4, 8'h00, 3'd5, 8'h00, 1'b1, 1'b0);

        // Three stalled cycles in the low-byte write
        start = 1'b1; op_a = 8'h03; op_b = 8'h05; rd = 3'd1;
        tick();
        c0 = cyc;
        start = 1'b0;
        tick();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we",   32'(rf_we), 32'd0);
            chk("stall_busy", 32'(busy),  32'd1);
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        chk("stall_lo_addr", 32'(rf_waddr), 32'd1);
        chk("stall_lo_data", 32'(rf_wdata), 32'h0F);
        tick();
        @(negedge clk);
        chk("stall_hi_done", 32'(done),     32'd1);
        chk("stall_hi_addr", 32'(rf_waddr), 32'd2);
        chk("stall_done_lat", 32'(cyc - c0), 32'd5);
        tick();

        // Start during CALC must be ignored
        start = 1'b1; op_a = 8'h11; op_b = 8'h22; rd = 3'd3;
        tick();
        op_a = 8'h99; op_b = 8'h77; rd = 3'd6;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("ign_lo_addr", 32'(rf_waddr), 32'd3);
        chk("ign_lo_data", 32'(rf_wdata), 32'h42);
        chk("ign_mulb",    32'(mul_b),    32'h22);
        tick();
        @(negedge clk);
        chk("ign_hi_addr", 32'(rf_waddr), 32'd4);
        chk("ign_hi_data", 32'(rf_wdata), 32'h02);
        tick();
        @(negedge clk);
        chk("ign_not_queued", 32'(busy), 32'd0);
        chk("ign_mula",       32'(mul_a), 32'h11);
        tick();

        // Reset in the low-byte write aborts the operation
        start = 1'b1; op_a = 8'h0C; op_b = 8'h0A; rd = 3'd2;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",   32'(rf_we),    32'd0);
        chk("arst_busy", 32'(busy),     32'd0);
        chk("arst_addr", 32'(rf_waddr), 32'd0);
        chk("arst_mula", 32'(mul_a),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_write", 32'(rf_we), 32'd0);
            tick();
        end
        op_lit(8'h0C, 8'h0A, 3'd2, 3'd2, 8'h78, 3'd3, 8'h00, 1'b0, 1'b0);

        // Start on the first edge after reset release
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        op_lit(8'h02, 8'h09, 3'd5, 3'd5, 8'h12, 3'd6, 8'h00, 1'b0, 1'b0);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom % 3) != 0;
            op_a     = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            op_b     = 8'($urandom);
            rd       = ADDR_W'($urandom);
            wb_stall = ($urandom % 4) == 0;
            tick();
        end
        start = 1'b0;
        wb_stall = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
